// File: rtl/conv_result_writer.sv
// conv_result_writer: packs 8-bit results four at a time into 32-bit words
// and writes them to consecutive word addresses of the result memory.
module conv_result_writer #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  out_count,
   input  logic              res_valid,
   input  logic [7:0]        res_data,
   output logic              res_ready,
   input  logic              mem_busy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [CNT_W-1:0]  remaining_r, remaining_s;
   logic [1:0]        lane_r, lane_s;
   logic [31:0]       pack_r, pack_s;

   // State register; reset always returns to IDLE and drops any partial word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath registers: write address, remaining-byte count, lane index, pack word.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r      <= '0;
         remaining_r <= '0;
         lane_r      <= 2'd0;
         pack_r      <= 32'h0000_0000;
      end else begin
         addr_r      <= addr_s;
         remaining_r <= remaining_s;
         lane_r      <= lane_s;
         pack_r      <= pack_s;
      end
   end

   // Next-state and next-datapath logic; every register holds unless a transfer occurs.
   always_comb begin
      state_s     = state_r;
      addr_s      = addr_r;
      remaining_s = remaining_r;
      lane_s      = lane_r;
      pack_s      = pack_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               addr_s      = base_addr;
               remaining_s = out_count;
               lane_s      = 2'd0;
               pack_s      = 32'h0000_0000;
               if (out_count == '0) begin
                  state_s = DONE;
               end else begin
                  state_s = COLLECT;
               end
            end else begin
               state_s = IDLE;
            end
         end
         COLLECT: begin
            if (res_valid) begin
               // Byte k of a word lands in bits [8k+7:8k]; unfilled lanes stay zero.
               pack_s[{lane_r, 3'b000} +: 8] = res_data;
               remaining_s = remaining_r - CNT_ONE;
               lane_s      = lane_r + 2'd1;
               if ((lane_r == 2'd3) || (remaining_r == CNT_ONE)) begin
                  state_s = WRITE;
               end else begin
                  state_s = COLLECT;
               end
            end else begin
               state_s = COLLECT;
            end
         end
         WRITE: begin
            // A busy memory freezes everything so address and data stay stable.
            if (!mem_busy) begin
               addr_s = addr_r + ADDR_ONE;
               lane_s = 2'd0;
               pack_s = 32'h0000_0000;
               if (remaining_r != '0) begin
                  state_s = COLLECT;
               end else begin
                  state_s = DONE;
               end
            end else begin
               state_s = WRITE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Outputs come only from state and registers, never directly from inputs.
   assign res_ready = (state_r == COLLECT);
   assign mem_we    = (state_r == WRITE);
   assign busy      = (state_r != IDLE);
   assign done      = (state_r == DONE);
   assign mem_addr  = addr_r;
   assign mem_wdata = pack_r;

endmodule
